// File: rtl/cbd_sampler.sv
// -----------------------------------------------------------------------------
// cbd_sampler
//
// Centered-binomial sampler for Kyber (q = 3329). Consumes a stream of 32-bit
// uniform random words and produces one 256-coefficient polynomial per start,
// delivered as BEATS beats of 16 coefficients (COEF_W bits each, value mod Q).
//
// Each beat is built from W fresh words (W = 2 for eta=2, 3 for eta=3). No
// random bits carry over between beats. The last word of a beat is not
// buffered: it is combined directly with the stored words and the finished
// beat is registered into out_data.
//
// Optional feature macro: CBD_ETA3_EN
//   defined     : eta=3 datapath present, eta3_i (latched at start) selects eta
//   not defined : eta=2 only, eta3_i ignored, 32-bit word store, W fixed at 2
//
// Ports
//   clk_i         in   clock, all logic on rising edge
//   rst_i         in   asynchronous active-low reset
//   start_i       in   begin a polynomial (sampled only in IDLE)
//   eta3_i        in   eta select, latched at start (1 -> eta=3)
//   rand_i        in   [31:0] random word
//   rand_valid_i  in   rand_i valid
//   rand_ready_o  out  sampler accepts rand_i (high only while filling)
//   out_data_o    out  [BEAT_W-1:0] coefficient k in bits [COEF_W*k +: COEF_W]
//   out_valid_o   out  beat valid, data held until out_ready_i
//   out_ready_i   in   downstream accepts beat
//   busy_o        out  not in IDLE
//   done_o        out  one-cycle pulse after the last beat handshake
// -----------------------------------------------------------------------------
module cbd_sampler #(
  parameter int Q      = 3329,
  parameter int COEF_W = 12,
  parameter int BEAT_W = 192,
  parameter int BEATS  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              eta3_i,
  input  logic [31:0]       rand_i,
  input  logic              rand_valid_i,
  output logic              rand_ready_o,
  output logic [BEAT_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int NCOEF = BEAT_W / COEF_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Only the words preceding the last word of a beat are stored.
`ifdef CBD_ETA3_EN
  localparam int STORE_W = 64;
`else
  localparam int STORE_W = 32;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         word_cnt;
  logic [CNT_W-1:0]   beat_cnt;
  logic [STORE_W-1:0] buf_q;

  logic               word_fire;
  logic               last_word;
  logic [1:0]         last_idx;
  logic [BEAT_W-1:0]  next_beat;

  // ---------------------------------------------------------------------------
  // Coefficient arithmetic
  // ---------------------------------------------------------------------------

  // a - c in the range -3..3, mapped to [0, Q). Working on the magnitude keeps
  // the arithmetic unsigned.
  function automatic logic [COEF_W-1:0] to_mod_q(input logic [1:0] a,
                                                  input logic [1:0] c);
    logic [COEF_W-1:0] r;
    if (a >= c) r = COEF_W'(a - c);
    else        r = COEF_W'(Q - int'(c - a));
    return r;
  endfunction

  function automatic logic [COEF_W-1:0] cbd2(input logic [3:0] b);
    logic [1:0] a;
    logic [1:0] c;
    a = {1'b0, b[0]} + {1'b0, b[1]};
    c = {1'b0, b[2]} + {1'b0, b[3]};
    return to_mod_q(a, c);
  endfunction

  logic [63:0]       bits2;
  logic [BEAT_W-1:0] beat2;

  assign bits2 = {rand_i, buf_q[31:0]};

  always_comb begin
    // NOTE: default assignment first so no path leaves beat2 unassigned,
    // which would otherwise infer a latch.
    beat2 = '0;
    for (int k = 0; k < NCOEF; k++) begin
      beat2[k*COEF_W +: COEF_W] = cbd2(bits2[4*k +: 4]);
    end
  end

`ifdef CBD_ETA3_EN
  function automatic logic [COEF_W-1:0] cbd3(input logic [5:0] b);
    logic [1:0] a;
    logic [1:0] c;
    a = {1'b0, b[0]} + {1'b0, b[1]} + {1'b0, b[2]};
    c = {1'b0, b[3]} + {1'b0, b[4]} + {1'b0, b[5]};
    return to_mod_q(a, c);
  endfunction

  logic              eta3_q;
  logic [95:0]       bits3;
  logic [BEAT_W-1:0] beat3;

  assign bits3 = {rand_i, buf_q[63:0]};

  always_comb begin
    beat3 = '0;
    for (int k = 0; k < NCOEF; k++) begin
      beat3[k*COEF_W +: COEF_W] = cbd3(bits3[6*k +: 6]);
    end
  end

  assign next_beat = eta3_q ? beat3 : beat2;
  assign last_idx  = eta3_q ? 2'd2 : 2'd1;
`else
  logic unused_eta3;
  assign unused_eta3 = eta3_i;
  assign next_beat   = beat2;
  assign last_idx    = 2'd1;
`endif

  assign word_fire = rand_valid_i && rand_ready_o;
  assign last_word = (word_cnt == last_idx);

  // ---------------------------------------------------------------------------
  // Word store
  // ---------------------------------------------------------------------------
  // NOTE: the word store has no reset; every slot is rewritten before it is
  // read for a beat, so stale content after reset is never observed.
  always_ff @(posedge clk_i) begin
    if (word_fire && !last_word) begin
`ifdef CBD_ETA3_EN
      if (word_cnt[0]) buf_q[63:32] <= rand_i;
      else             buf_q[31:0]  <= rand_i;
`else
      buf_q <= rand_i;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      word_cnt     <= '0;
      beat_cnt     <= '0;
`ifdef CBD_ETA3_EN
      eta3_q       <= 1'b0;
`endif
      rand_ready_o <= 1'b0;
      out_data_o   <= '0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
`ifdef CBD_ETA3_EN
            eta3_q     <= eta3_i;
`endif
            word_cnt     <= '0;
            beat_cnt     <= '0;
            rand_ready_o <= 1'b1;
            busy_o       <= 1'b1;
            state        <= FILL;
          end
        end

        FILL: begin
          if (word_fire) begin
            if (last_word) begin
              out_data_o   <= next_beat;
              out_valid_o  <= 1'b1;
              rand_ready_o <= 1'b0;
              state        <= OUT;
            end else begin
              word_cnt <= word_cnt + 2'd1;
            end
          end
        end

        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            word_cnt    <= '0;
            beat_cnt    <= beat_cnt + CNT_W'(1);
            if (beat_cnt == LAST_BEAT) begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              rand_ready_o <= 1'b1;
              state        <= FILL;
            end
          end
        end

        default: begin
          rand_ready_o <= 1'b0;
          out_valid_o  <= 1'b0;
          busy_o       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_sampler.sv
// -----------------------------------------------------------------------------
// tb_cbd_sampler
//
// Self-checking bench for cbd_sampler. A bus-functional process on the falling
// edge feeds words from a source queue, drives out_ready and compares every
// accepted beat against a reference model pushed to a scoreboard queue when
// each polynomial's stimulus is prepared. The main initial block runs the
// directed scenarios in sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cbd_sampler;

`ifdef CBD_ETA3_EN
  localparam bit ETA3_EN = 1'b1;
`else
  localparam bit ETA3_EN = 1'b0;
`endif
  localparam int Q = 3329;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         eta3_i;
  logic [31:0]  rand_i;
  logic         rand_valid_i;
  logic         rand_ready_o;
  logic [191:0] out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         busy_o;
  logic         done_o;

  cbd_sampler dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .eta3_i       (eta3_i),
    .rand_i       (rand_i),
    .rand_valid_i (rand_valid_i),
    .rand_ready_o (rand_ready_o),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [31:0]  src_q[$];
  logic [191:0] exp_q[$];
  logic [31:0]  pat[48];

  int           hs_count    = 0;
  int           hs_base     = 0;
  int           words_taken = 0;
  int           stall_at    = -1;
  bit           gap_en      = 1'b0;
  logic [191:0] first_beat  = '0;

  task automatic check(input string tag, input logic [191:0] obs,
                       input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: coefficient k of a beat from the beat's raw bits.
  function automatic logic [191:0] model_beat(input logic [95:0] bits,
                                              input bit eta3);
    logic [191:0] r;
    int a, c, v;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (eta3) begin
        a = int'(bits[6*k])   + int'(bits[6*k+1]) + int'(bits[6*k+2]);
        c = int'(bits[6*k+3]) + int'(bits[6*k+4]) + int'(bits[6*k+5]);
      end else begin
        a = int'(bits[4*k])   + int'(bits[4*k+1]);
        c = int'(bits[4*k+2]) + int'(bits[4*k+3]);
      end
      v = a - c;
      r[12*k +: 12] = (v < 0) ? 12'(Q + v) : 12'(v);
    end
    return r;
  endfunction

  // Push the words of pat[] to the source and the expected beats to the
  // scoreboard. A requested eta=3 falls back to eta=2 when the feature is
  // compiled out.
  task automatic queue_poly(input bit eta3);
    bit           e;
    int           w;
    logic [95:0]  bits;
    e = eta3 && ETA3_EN;
    w = e ? 3 : 2;
    for (int b = 0; b < 16; b++) begin
      bits = '0;
      for (int j = 0; j < w; j++) begin
        bits[32*j +: 32] = pat[b*w+j];
        src_q.push_back(pat[b*w+j]);
      end
      exp_q.push_back(model_beat(bits, e));
    end
  endtask

  task automatic fill_pat_random();
    for (int i = 0; i < 48; i++) pat[i] = $urandom;
  endtask

  task automatic fill_pat_const(input logic [31:0] w);
    for (int i = 0; i < 48; i++) pat[i] = w;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rand_ready"}, rand_ready_o, 0);
    check({tag, "_out_valid"},  out_valid_o,  0);
    check({tag, "_out_data"},   out_data_o,   0);
    check({tag, "_busy"},       busy_o,       0);
    check({tag, "_done"},       done_o,       0);
  endtask

  // Reset in the middle of a polynomial; everything queued is discarded.
  task automatic do_reset();
    #2 rst_i = 1'b0;
    #1 check_reset_outputs("midrst");
    src_q.delete();
    exp_q.delete();
    @(negedge clk_i);
    check("midrst_hold_done", done_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_post_busy", busy_o, 0);
    check("midrst_post_valid", out_valid_o, 0);
  endtask

  // Start a polynomial at the current falling edge and wait for done.
  // exp_cycles/exp_words of 0 skip that comparison; pulse_at/reset_at of -1
  // disable the mid-run start pulse / mid-run reset.
  task automatic run_poly(input bit eta3, input int exp_cycles,
                          input int exp_words, input int pulse_at,
                          input int reset_at);
    int cyc;
    int words_base;
    bit pulsed;
    hs_base    = hs_count;
    words_base = words_taken;
    eta3_i     = eta3;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    eta3_i  = ~eta3;
    check("ready_rise", rand_ready_o, 1);
    check("busy_rise", busy_o, 1);
    cyc    = 0;
    pulsed = 1'b0;
    while (done_o !== 1'b1 && cyc < 2000) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'b0;
      if (!pulsed && pulse_at >= 0 && hs_count - hs_base >= pulse_at) begin
        start_i = 1'b1;
        pulsed  = 1'b1;
      end
      if (reset_at >= 0 && hs_count - hs_base >= reset_at) begin
        do_reset();
        return;
      end
    end
    check("done_seen", done_o, 1);
    if (exp_cycles > 0) check("fill_to_done_cycles", cyc, exp_cycles);
    check("beats", hs_count - hs_base, 16);
    if (exp_words > 0) check("words_used", words_taken - words_base, exp_words);
    check("scoreboard_empty", exp_q.size(), 0);
    check("busy_at_done", busy_o, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Falling-edge driver / monitor
  // ---------------------------------------------------------------------------
  int           stall_left = 0;
  int           stalled_at = -1;
  bit           prev_stall = 1'b0;
  logic [191:0] held_data  = '0;
  int           held_words = 0;
  logic [191:0] exp_beat;

  always @(negedge clk_i) begin
    if (prev_stall) begin
      check("stall_valid", out_valid_o, 1);
      check("stall_data", out_data_o, held_data);
      check("stall_rand_ready", rand_ready_o, 0);
      check("stall_words", src_q.size(), held_words);
    end

    if (stall_left > 0) begin
      out_ready_i = 1'b0;
      stall_left--;
    end else if (out_valid_o === 1'b1 && stall_at >= 0 &&
                 hs_count == stall_at && stalled_at != stall_at) begin
      out_ready_i = 1'b0;
      stall_left  = 9;
      stalled_at  = stall_at;
    end else begin
      out_ready_i = 1'b1;
    end

    if (out_valid_o === 1'b1 && out_ready_i) begin
      if (exp_q.size() > 0) exp_beat = exp_q.pop_front();
      else                  exp_beat = 'x;
      check("beat_data", out_data_o, exp_beat);
      if (hs_count == hs_base) first_beat = out_data_o;
      hs_count++;
    end

    if (src_q.size() > 0 && (!gap_en || $urandom_range(1, 0) == 1)) begin
      rand_valid_i = 1'b1;
      rand_i       = src_q[0];
    end else begin
      rand_valid_i = 1'b0;
      rand_i       = $urandom;
    end
    if (rand_valid_i && rand_ready_o === 1'b1) begin
      src_q.delete(0);
      words_taken++;
    end

    prev_stall = (out_valid_o === 1'b1) && !out_ready_i;
    held_data  = out_data_o;
    held_words = src_q.size();
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_i        = 1'b0;
    start_i      = 1'b0;
    eta3_i       = 1'b0;
    rand_i       = '0;
    rand_valid_i = 1'b0;
    out_ready_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    check("idle_busy", busy_o, 0);
    check("idle_rand_ready", rand_ready_o, 0);

    // eta=2, all-zero words
    fill_pat_const(32'h0000_0000);
    queue_poly(1'b0);
    run_poly(1'b0, 48, 32, -1, -1);
    check("zero_first_beat", first_beat, 0);
    @(negedge clk_i);
    check("done_single_cycle", done_o, 0);

    // eta=2, first word 0xC -> coefficient 0 is -2
    fill_pat_const(32'h0000_0000);
    pat[0] = 32'h0000_000C;
    queue_poly(1'b0);
    run_poly(1'b0, 48, 32, -1, -1);
    check("c_coef0", first_beat[11:0], 12'hCFF);
    check("c_others", first_beat[191:12], 0);

    // back-to-back start in the done cycle; first word 0x3 -> coefficient +2
    fill_pat_random();
    pat[0] = 32'h0000_0003;
    queue_poly(1'b0);
    run_poly(1'b0, 48, 32, -1, -1);
    check("three_coef0", first_beat[11:0], 12'h002);

    // eta=2, all-ones words
    fill_pat_const(32'hFFFF_FFFF);
    queue_poly(1'b0);
    run_poly(1'b0, 48, 32, -1, -1);
    check("ones_first_beat", first_beat, 0);

    // eta=3 request (eta=2 when the feature is compiled out); eta3_i flips
    // after start inside run_poly
    @(negedge clk_i);
    fill_pat_random();
    pat[0] = 32'h0000_0E38;
    queue_poly(1'b1);
    run_poly(1'b1, ETA3_EN ? 64 : 48, ETA3_EN ? 48 : 32, -1, -1);
    check("eta_sel_coef0", first_beat[11:0], ETA3_EN ? 12'hCFE : 12'hD00);
    check("eta_sel_coef1", first_beat[23:12], ETA3_EN ? 12'hCFE : 12'h002);

    // backpressure on beat 5 for 10 cycles
    @(negedge clk_i);
    fill_pat_random();
    queue_poly(1'b0);
    stall_at = hs_count + 5;
    run_poly(1'b0, 58, 32, -1, -1);
    stall_at = -1;

    // random rand_valid gaps and a stray start pulse during beat 3
    @(negedge clk_i);
    fill_pat_random();
    queue_poly(1'b0);
    gap_en = 1'b1;
    run_poly(1'b0, 0, 32, 3, -1);
    gap_en = 1'b0;
    repeat (3) @(negedge clk_i);
    check("after_stray_start_busy", busy_o, 0);
    check("after_stray_start_beats", hs_count - hs_base, 16);

    // reset during beat 8, then a fresh polynomial
    fill_pat_random();
    queue_poly(1'b0);
    run_poly(1'b0, 0, 0, -1, 8);
    fill_pat_random();
    pat[0] = 32'h0000_000C;
    queue_poly(1'b0);
    run_poly(1'b0, 48, 32, -1, -1);
    check("restart_coef0", first_beat[11:0], 12'hCFF);

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
